mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Multi-cycle multiply/divide responder for the execute stage.
- Accepts one M-extension operation per request (alufunc_t codes ALU_MUL..ALU_REMUW) over a valid/ready handshake.
- Computes it iteratively and returns the 64-bit result through a second valid/ready handshake.
- The execute stage is the initiator and stalls the pipeline while waiting.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- CNT_W, 7, width of the iteration counter (holds 0..64).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of any in-flight or pending operation.
- req_valid  in  1  initiator presents an operation.
- req_ready  out  1  block can accept; high only in IDLE.
- req_func  in  5  alufunc_t encoding: MUL=16, DIV=17, REM=18, DIVU=19, REMU=20, MULW=21, DIVW=22, REMW=23, DIVUW=24, REMUW=25.
- req_a  in  64  rs1 value (dividend / multiplicand).
- req_b  in  64  rs2 value (divisor / multiplier).
- resp_valid  out  1  result available.
- resp_ready  in  1  initiator consumes the result.
- resp_data  out  64  result.

Behaviour:
- Reset: asynchronous. State goes to IDLE; req_ready=1, resp_valid=0, resp_data=0; counter and datapath registers cleared.
  - Reset asserted mid-operation discards the operation with no response.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY: on the edge where req_valid & req_ready & !flush. Operands, func and sign flags are latched. Counter is loaded with N=64 for 64-bit ops or N=32 for W ops.
- BUSY: one iteration per cycle, counter decrements. Leaves for DONE on the edge where the counter reaches 0, with the final correction and sign fix-up applied on that edge.
  - If accepted in cycle C, BUSY spans C+1..C+N and resp_valid is first high in cycle C+N+1.
- DONE: resp_valid=1 and resp_data stable until the edge where resp_ready=1, then go to IDLE.
  - req_ready stays 0 in DONE, so a new request is only accepted starting the cycle after the response handshake.
- flush: in any state, go to IDLE on the next edge. resp_valid=0 from that edge. No response is produced for the aborted operation. flush wins over a simultaneous request or response handshake.
- Multiply: shift-add on unsigned operands.
  - MUL returns the low 64 bits of the product.
  - MULW multiplies the low 32 bits, then sign-extends bit 31 of the 32-bit product to 64 bits.
- Divide: restoring division on magnitudes.
  - Signed ops take absolute values first. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - W ops use the low 32 bits of each operand (sign- or zero-extended per op), and results are sign-extended from bit 31.
- Divide by zero (divisor field == 0): quotient = all ones (W: 0xFFFFFFFF sign-extended); remainder = dividend (W: low 32 bits sign-extended).
- Signed overflow (dividend = most negative value, divisor = -1): quotient = dividend; remainder = 0. Widths follow the op.
- Any req_func outside 16..25 is accepted with N=1 and returns resp_data=0.
- resp_data holds its last value in IDLE and BUSY; it is not cleared after the handshake.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow cases skip BUSY. IDLE goes directly to DONE with the special result, so resp_valid is high in cycle C+1.
- Not defined: these cases run the full N iterations and produce the identical special result at C+N+1.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- MUL a=0x0000_0000_0000_0007, b=0xFFFF_FFFF_FFFF_FFFD -> resp_data=0xFFFF_FFFF_FFFF_FFEB; resp_valid first at C+65.
- DIVW a=0x0000_0000_FFFF_FFF9 (-7), b=2 -> 0xFFFF_FFFF_FFFF_FFFD at C+33; REMW with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU a=100, b=0 -> 0xFFFF_FFFF_FFFF_FFFF; REM a=0x8000_0000_0000_0000, b=-1 -> 0. Both at C+65 without MDU_EARLY_OUT_EN, C+1 with it.
- Result hold: hold resp_ready=0 for 5 cycles in DONE -> resp_valid and resp_data stable, req_ready=0. Then resp_ready=1 -> IDLE next edge with req_ready=1.
- Abort: flush at cycle C+10 of a DIV -> IDLE next edge, no resp_valid ever. A new MULW a=3, b=5 accepted afterwards -> 15 at its own C+33.
- Asynchronous reset pulse mid-BUSY (between clock edges) -> outputs reach reset values immediately, not on the next edge. After release, a REMU a=17, b=5 -> 2.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative M-extension multiply/divide unit: shift-add multiply, restoring divide, valid/ready on both sides.
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero and signed-overflow results bypass the iteration phase.
module mdu_iter #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [4:0]      req_func,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data
);

   localparam int HALF = XLEN / 2;

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;
`else
   localparam bit EARLY_OUT = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   state_t            w_nextState;

   logic [XLEN-1:0]   r_acc;
   logic [XLEN-1:0]   r_div;
   logic [XLEN-1:0]   r_q;
   logic [CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   r_result;
   logic [XLEN-1:0]   r_specialRes;
   logic              r_isMul;
   logic              r_isW;
   logic              r_isRem;
   logic              r_negQ;
   logic              r_negR;
   logic              r_invalid;
   logic              r_special;

   logic              w_accept;
   logic              w_reqIsMul;
   logic              w_reqValidFunc;
   logic              w_reqIsW;
   logic              w_reqIsSigned;
   logic              w_reqIsRem;
   logic [XLEN-1:0]   w_aExt;
   logic [XLEN-1:0]   w_bExt;
   logic [XLEN-1:0]   w_aSext32;
   logic [XLEN-1:0]   w_minVal;
   logic              w_aNeg;
   logic              w_bNeg;
   logic [XLEN-1:0]   w_aMag;
   logic [XLEN-1:0]   w_bMag;
   logic              w_divZero;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_specialResIn;

   logic [XLEN-1:0]   w_prodNext;
   logic [XLEN:0]     w_shift;
   logic              w_fits;
   logic [XLEN-1:0]   w_remNext;
   logic [XLEN-1:0]   w_quoNext;
   logic [XLEN-1:0]   w_quoRaw;
   logic [XLEN-1:0]   w_quoFix;
   logic [XLEN-1:0]   w_remFix;
   logic [XLEN-1:0]   w_sel;
   logic [XLEN-1:0]   w_res;
   logic [XLEN-1:0]   w_final;
   logic              w_lastIter;

   assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
   assign w_lastIter = (r_state == S_BUSY) && (r_cnt == CNT_W'(1));

   // Request decode; W ops work on the low half, extended according to signedness.
   always_comb begin
      w_reqIsMul     = (req_func == 5'd16) || (req_func == 5'd21);
      w_reqValidFunc = (req_func >= 5'd16) && (req_func <= 5'd25);
      w_reqIsW       = (req_func >= 5'd21) && (req_func <= 5'd25);
      w_reqIsSigned  = (req_func == 5'd17) || (req_func == 5'd18) ||
                       (req_func == 5'd22) || (req_func == 5'd23);
      w_reqIsRem     = (req_func == 5'd18) || (req_func == 5'd20) ||
                       (req_func == 5'd23) || (req_func == 5'd25);
      w_aSext32      = {{HALF{req_a[HALF-1]}}, req_a[HALF-1:0]};
      w_aExt         = req_a;
      w_bExt         = req_b;
      w_minVal       = {1'b1, {(XLEN-1){1'b0}}};
      if (w_reqIsW) begin
         w_aExt   = w_reqIsSigned ? w_aSext32 : {{HALF{1'b0}}, req_a[HALF-1:0]};
         w_bExt   = w_reqIsSigned ? {{HALF{req_b[HALF-1]}}, req_b[HALF-1:0]}
                                  : {{HALF{1'b0}}, req_b[HALF-1:0]};
         w_minVal = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
      end
      w_aNeg    = w_reqIsSigned && w_aExt[XLEN-1];
      w_bNeg    = w_reqIsSigned && w_bExt[XLEN-1];
      w_aMag    = w_aNeg ? -w_aExt : w_aExt;
      w_bMag    = w_bNeg ? -w_bExt : w_bExt;
      w_divZero = (w_bExt == '0);
      w_ovf     = w_reqIsSigned && (w_aExt == w_minVal) && (w_bExt == '1);
      w_special = w_reqValidFunc && !w_reqIsMul && (w_divZero || w_ovf);
      if (w_divZero)
         w_specialResIn = w_reqIsRem ? (w_reqIsW ? w_aSext32 : req_a) : '1;
      else
         w_specialResIn = w_reqIsRem ? '0 : (w_reqIsW ? w_aSext32 : req_a);
   end

   // One iteration step for each datapath, plus the sign/width fix-up of the last step.
   always_comb begin
      w_prodNext = r_acc + (r_q[0] ? r_div : '0);
      w_shift    = {r_acc, r_q[XLEN-1]};
      w_fits     = (w_shift >= {1'b0, r_div});
      w_remNext  = w_fits ? XLEN'(w_shift - {1'b0, r_div}) : w_shift[XLEN-1:0];
      w_quoNext  = {r_q[XLEN-2:0], w_fits};
      w_quoRaw   = r_isW ? {{HALF{1'b0}}, w_quoNext[HALF-1:0]} : w_quoNext;
      w_quoFix   = r_negQ ? -w_quoRaw : w_quoRaw;
      w_remFix   = r_negR ? -w_remNext : w_remNext;
      w_sel      = r_isMul ? w_prodNext : (r_isRem ? w_remFix : w_quoFix);
      w_res      = r_isW ? {{HALF{w_sel[HALF-1]}}, w_sel[HALF-1:0]} : w_sel;
      if (r_invalid)
         w_final = '0;
      else if (r_special)
         w_final = r_specialRes;
      else
         w_final = w_res;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_nextState = (EARLY_OUT && w_special) ? S_DONE : S_BUSY;
         S_BUSY: if (r_cnt == CNT_W'(1)) w_nextState = S_DONE;
         S_DONE: if (resp_ready) w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
      if (flush)
         w_nextState = S_IDLE;
   end

   always_comb begin
      req_ready  = (r_state == S_IDLE);
      resp_valid = (r_state == S_DONE);
   end

   assign resp_data = r_result;

   // Multiply reuses r_acc/r_div/r_q as product/multiplicand/multiplier; divide as remainder/divisor/quotient.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc        <= '0;
         r_div        <= '0;
         r_q          <= '0;
         r_cnt        <= '0;
         r_result     <= '0;
         r_specialRes <= '0;
         r_isMul      <= 1'b0;
         r_isW        <= 1'b0;
         r_isRem      <= 1'b0;
         r_negQ       <= 1'b0;
         r_negR       <= 1'b0;
         r_invalid    <= 1'b0;
         r_special    <= 1'b0;
      end else if (w_accept) begin
         r_acc        <= '0;
         r_isMul      <= w_reqIsMul;
         r_isW        <= w_reqIsW;
         r_isRem      <= w_reqIsRem;
         r_negQ       <= w_reqIsSigned && (w_aNeg ^ w_bNeg);
         r_negR       <= w_aNeg;
         r_invalid    <= !w_reqValidFunc;
         r_special    <= w_special;
         r_specialRes <= w_specialResIn;
         if (!w_reqValidFunc)
            r_cnt <= CNT_W'(1);
         else
            r_cnt <= w_reqIsW ? CNT_W'(HALF) : CNT_W'(XLEN);
         if (w_reqIsMul) begin
            r_div <= w_aExt;
            r_q   <= w_bExt;
         end else begin
            r_div <= w_bMag;
            r_q   <= w_reqIsW ? {w_aMag[HALF-1:0], {HALF{1'b0}}} : w_aMag;
         end
         if (EARLY_OUT && w_special)
            r_result <= w_specialResIn;
      end else if (r_state == S_BUSY && !flush) begin
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_isMul) begin
            r_acc <= w_prodNext;
            r_div <= r_div << 1;
            r_q   <= r_q >> 1;
         end else begin
            r_acc <= w_remNext;
            r_q   <= w_quoNext;
         end
         if (w_lastIter)
            r_result <= w_final;
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, corner sequences and randomized ops against a reference model.
module tb_mdu_iter;

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam int SPEC_LAT   = EARLY ? 1 : 65;
   localparam int SPEC_LAT_W = EARLY ? 1 : 33;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_func = 5'd0;
   logic [63:0] req_a = '0;
   logic [63:0] req_b = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_data;

   int checks = 0;
   int errors = 0;

   mdu_iter dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
      .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  f;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] expData;
      int          expLat;
   } vec_t;

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Reference results straight from the M-extension arithmetic rules.
   function automatic logic [63:0] refModel(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b);
      longint      sa, sb;
      int          wa, wb;
      int unsigned ua, ub;
      logic [31:0] r;
      sa = longint'(a); sb = longint'(b);
      wa = int'(a[31:0]); wb = int'(b[31:0]);
      ua = a[31:0]; ub = b[31:0];
      case (f)
         5'd16: return a * b;
         5'd21: begin r = a[31:0] * b[31:0]; return sx32(r); end
         5'd17: if (b == 0) return '1; else if (a == MIN64 && sb == -1) return a; else return 64'(sa / sb);
         5'd18: if (b == 0) return a; else if (a == MIN64 && sb == -1) return '0; else return 64'(sa % sb);
         5'd19: if (b == 0) return '1; else return a / b;
         5'd20: if (b == 0) return a; else return a % b;
         5'd22: if (wb == 0) return '1; else if (wa == 32'sh8000_0000 && wb == -1) return sx32(a[31:0]);
                else begin r = 32'(wa / wb); return sx32(r); end
         5'd23: if (wb == 0) return sx32(a[31:0]); else if (wa == 32'sh8000_0000 && wb == -1) return '0;
                else begin r = 32'(wa % wb); return sx32(r); end
         5'd24: if (ub == 0) return '1; else begin r = ua / ub; return sx32(r); end
         5'd25: if (ub == 0) return sx32(a[31:0]); else begin r = ua % ub; return sx32(r); end
         default: return '0;
      endcase
   endfunction

   // Cycles from acceptance to the first cycle with a visible response.
   function automatic int refLatency(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b);
      bit isW, isSigned, special;
      if (f < 5'd16 || f > 5'd25) return 2;
      isW      = (f >= 5'd21);
      isSigned = (f == 5'd17 || f == 5'd18 || f == 5'd22 || f == 5'd23);
      special  = 1'b0;
      if (f != 5'd16 && f != 5'd21) begin
         if (isW) special = (b[31:0] == 0) || (isSigned && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
         else     special = (b == 0) || (isSigned && a == MIN64 && b == '1);
      end
      if (EARLY && special) return 1;
      return isW ? 33 : 65;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Issue one request from IDLE, wait (bounded) for the response, consume it.
   task automatic applyStimulus(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] data, output int lat);
      req_func = f; req_a = a; req_b = b; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      data = resp_data;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   function automatic logic [63:0] pickOperand();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return 64'd1;
         2: return '1;
         3: return MIN64;
         4: return 64'h0000_0000_8000_0000;
         5: return 64'($urandom_range(0, 200));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      vec_t        vecs[12];
      logic [63:0] data, held;
      int          lat;
      bit          ok;

      vecs[0]  = '{5'd16, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
      vecs[1]  = '{5'd22, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
      vecs[2]  = '{5'd23, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
      vecs[3]  = '{5'd19, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC_LAT};
      vecs[4]  = '{5'd18, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, SPEC_LAT};
      vecs[5]  = '{5'd21, 64'd3, 64'd5, 64'd15, 33};
      vecs[6]  = '{5'd20, 64'd17, 64'd5, 64'd2, 65};
      vecs[7]  = '{5'd22, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, SPEC_LAT_W};
      vecs[8]  = '{5'd25, 64'h0000_0001_8000_0007, 64'h0000_0005_0000_0000, 64'hFFFF_FFFF_8000_0007, SPEC_LAT_W};
      vecs[9]  = '{5'd5, 64'd1234, 64'd99, 64'd0, 2};
      vecs[10] = '{5'd21, 64'h0001_0000, 64'h8000, 64'hFFFF_FFFF_8000_0000, 33};
      vecs[11] = '{5'd17, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};

      repeat (2) @(negedge clk);
      checkOutput("reset req_ready", 64'(req_ready), 64'd1);
      checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("reset resp_data", resp_data, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, data, lat);
         checkOutput($sformatf("vec%0d data", i), data, vecs[i].expData);
         checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].expLat));
      end

      // Result hold while the initiator withholds resp_ready.
      req_func = 5'd16; req_a = 64'd7; req_b = 64'hFFFF_FFFF_FFFF_FFFD; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 300) begin @(negedge clk); lat++; end
      held = resp_data;
      ok = resp_valid;
      repeat (5) begin
         @(negedge clk);
         if (!resp_valid || resp_data !== held || req_ready) ok = 1'b0;
      end
      checkOutput("hold stable", 64'(ok), 64'd1);
      checkOutput("hold data", held, 64'hFFFF_FFFF_FFFF_FFEB);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checkOutput("post-hold req_ready", 64'(req_ready), 64'd1);
      checkOutput("post-hold resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("post-hold data kept", resp_data, 64'hFFFF_FFFF_FFFF_FFEB);

      // Flush beats a simultaneous request in IDLE.
      req_func = 5'd17; req_a = 64'd50; req_b = 64'd5; req_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      checkOutput("flush vs request", 64'(req_ready), 64'd1);

      // Abort a DIV in its tenth cycle.
      req_func = 5'd17; req_a = 64'd1000; req_b = 64'd3; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("abort to idle", 64'(req_ready), 64'd1);
      ok = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (resp_valid) ok = 1'b1;
      end
      checkOutput("abort no response", 64'(ok), 64'd0);
      applyStimulus(5'd21, 64'd3, 64'd5, data, lat);
      checkOutput("after abort MULW data", data, 64'd15);
      checkOutput("after abort MULW latency", 64'(lat), 64'd33);

      // Asynchronous reset between edges in the middle of BUSY.
      req_func = 5'd17; req_a = 64'd1000; req_b = 64'd3; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("async reset req_ready", 64'(req_ready), 64'd1);
      checkOutput("async reset resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("async reset resp_data", resp_data, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      applyStimulus(5'd20, 64'd17, 64'd5, data, lat);
      checkOutput("after reset REMU data", data, 64'd2);
      checkOutput("after reset REMU latency", 64'(lat), 64'd65);

      // Randomized operations against the reference model.
      for (int i = 0; i < 60; i++) begin
         logic [4:0]  f;
         logic [63:0] a, b;
         f = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(16, 25));
         a = pickOperand();
         b = pickOperand();
         applyStimulus(f, a, b, data, lat);
         checkOutput($sformatf("rand%0d f=%0d a=%h b=%h data", i, f, a, b), data, refModel(f, a, b));
         checkOutput($sformatf("rand%0d f=%0d latency", i, f), 64'(lat), 64'(refLatency(f, a, b)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
